// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_uart_pkg - shared types and helpers for the FIFO-fed UART TX |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  localparam int unsigned c_data_bits = 8;

  function automatic int unsigned DIV_OF(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Start + data + optional parity + stop bits, in clock cycles.
  function automatic int unsigned FRAME_LEN(input int unsigned div, input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return (1 + c_data_bits + parity_en + stop_bits) * div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_baud_gen - bit-period counter, bit_end on the last cycle     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned c_cw = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  assign bit_end = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_uart_tx - drains a FIFO read port into 8-bit UART frames    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        txd,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] tx_count
);

  localparam int unsigned DIV = DIV_OF(CLK_HZ, BAUD);
  localparam logic [1:0]  c_lat_last  = 2'(RD_LATENCY - 1);
  localparam logic [2:0]  c_stop_last = 3'(STOP_BITS - 1);
  localparam logic        c_par_en    = (PARITY_EN != 0);
  localparam logic        c_par_odd   = (PARITY_ODD != 0);

  generate
    if (DIV < 2) begin : g_div_err
      $error("fifo_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_lat_err
      $error("fifo_uart_tx: RD_LATENCY must be 1..3");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_err
      $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_e   r_state, w_state_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [2:0]  r_bit, w_bit_n;
  logic [1:0]  r_lat, w_lat_n;
  logic        r_par, w_par_n;
  logic        r_txd, w_txd_n;
  logic [15:0] r_count, w_count_n;
  logic        w_bit_end;
  logic        w_clr;

  // Bit timing restarts from zero on entry to START, so hold it clear until then.
  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_WAIT);

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_clr),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_lat   <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_bit   <= w_bit_n;
      r_lat   <= w_lat_n;
      r_par   <= w_par_n;
      r_txd   <= w_txd_n;
      r_count <= w_count_n;
    end
  end

  // w_txd_n is the line level of the bit being entered, so txd is registered per bit.
  always_comb begin
    w_state_n  = r_state;
    w_shift_n  = r_shift;
    w_bit_n    = r_bit;
    w_lat_n    = r_lat;
    w_par_n    = r_par;
    w_txd_n    = r_txd;
    w_count_n  = r_count;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_txd_n = 1'b1;
        if (enable && !fifo_empty && !rst) begin
          fifo_rd_en = 1'b1;
          w_lat_n    = '0;
          w_state_n  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_lat == c_lat_last) begin
          w_shift_n = fifo_dout;
          w_par_n   = c_par_odd ^ (^fifo_dout);
          w_txd_n   = 1'b0;
          w_state_n = ST_START;
        end else begin
          w_lat_n = r_lat + 2'd1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_bit_n   = '0;
          w_txd_n   = r_shift[0];
          w_state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_bit_n = '0;
            if (c_par_en) begin
              w_txd_n   = r_par;
              w_state_n = ST_PARITY;
            end else begin
              w_txd_n   = 1'b1;
              w_state_n = ST_STOP;
            end
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
            w_txd_n   = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_bit_n   = '0;
          w_txd_n   = 1'b1;
          w_state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_bit == c_stop_last) begin
            tx_done   = 1'b1;
            w_count_n = r_count + 16'd1;
            w_state_n = ST_IDLE;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end
      end
      default: begin
        w_txd_n   = 1'b1;
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign txd      = r_txd;
  assign busy     = (r_state != ST_IDLE);
  assign tx_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_uart_tx - four configurations, FIFO models, frame monitor |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fifo_uart_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          DIV    = 10;
  localparam int          NCFG   = 4;
  localparam int unsigned LAT  [NCFG] = '{1, 1, 1, 2};
  localparam int unsigned PEN  [NCFG] = '{0, 1, 1, 0};
  localparam int unsigned PODD [NCFG] = '{0, 0, 1, 0};
  localparam int unsigned STB  [NCFG] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0] rst_v, en_v, push_req;
  logic [7:0]      push_dat;
  logic [NCFG-1:0] txd_v, busy_v, done_v, rd_v;
  logic [15:0]     cnt_v   [NCFG];
  int              rdc_v   [NCFG];
  int              uf_v    [NCFG];
  int              stray_v [NCFG];
  int              left_v  [NCFG];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line levels of one frame, bit 0 = start; unused upper bits stay at idle level.
  function automatic logic [31:0] exp_frame(input logic [7:0] d, input int unsigned pen,
                                            input int unsigned podd);
    logic [31:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pen != 0) f[9] = (podd != 0) ? ~(^d) : (^d);
    return f;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int NB = 10 + int'(PEN[g]) + int'(STB[g]) - 1;
    localparam int FL = NB * DIV;

    logic        empty = 1'b1;
    logic [7:0]  p0 = 8'h00, p1 = 8'h00, p2 = 8'h00;
    logic [7:0]  dout;
    logic [7:0]  q[$];
    logic [7:0]  sb[$];
    int          gaps[$];
    int          rd_cnt = 0, underflow = 0, stray = 0, left = 0;
    logic [15:0] cnt_model = 16'h0000;
    logic        txd, busy, tx_done, rd_en;
    logic [15:0] tx_count;

    assign dout = (LAT[g] == 1) ? p0 : (LAT[g] == 2) ? p1 : p2;

    fifo_uart_tx #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .RD_LATENCY(LAT[g]),
      .PARITY_EN (PEN[g]),
      .PARITY_ODD(PODD[g]),
      .STOP_BITS (STB[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst_v[g]),
      .enable    (en_v[g]),
      .fifo_empty(empty),
      .fifo_dout (dout),
      .fifo_rd_en(rd_en),
      .txd       (txd),
      .busy      (busy),
      .tx_done   (tx_done),
      .tx_count  (tx_count)
    );

    assign txd_v[g]   = txd;
    assign busy_v[g]  = busy;
    assign done_v[g]  = tx_done;
    assign rd_v[g]    = rd_en;
    assign cnt_v[g]   = tx_count;
    assign rdc_v[g]   = rd_cnt;
    assign uf_v[g]    = underflow;
    assign stray_v[g] = stray;
    assign left_v[g]  = left;

    // FIFO with read data appearing LAT cycles after the read strobe.
    always @(posedge clk) begin
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (q.size() == 0) underflow <= underflow + 1;
        else p0 <= q.pop_front();
      end
      if (push_req[g]) begin
        q.push_back(push_dat);
        sb.push_back(push_dat);
      end
      p1    <= p0;
      p2    <= p1;
      empty <= (q.size() == 0);
    end

    always @(negedge clk) left = sb.size();

    initial begin : mon
      int          idle;
      int          done_at;
      logic [7:0]  b;
      logic [31:0] obs;
      bit          stable;
      bit          aborted;
      idle = 0;
      forever begin
        @(negedge clk);
        if (rst_v[g]) begin
          idle = 0;
          cnt_model = 16'h0000;
          continue;
        end
        if (txd !== 1'b0) begin
          if (tx_done === 1'b1) stray++;
          idle++;
          continue;
        end
        gaps.push_back(idle);
        idle = 0;
        if (sb.size() != 0) b = sb.pop_front();
        else b = 8'hxx;
        chk($sformatf("d%0d count at frame start", g), tx_count, cnt_model);
        obs = '1;
        stable = 1'b1;
        aborted = 1'b0;
        done_at = -1;
        for (int c = 0; c < FL; c++) begin
          if (c != 0) @(negedge clk);
          if (rst_v[g]) begin
            aborted = 1'b1;
            break;
          end
          if (c % DIV == 0) obs[c / DIV] = txd;
          else if (txd !== obs[c / DIV]) stable = 1'b0;
          if (busy !== 1'b1) stable = 1'b0;
          if (tx_done === 1'b1) done_at = (done_at < 0) ? c : -2;
        end
        if (aborted) begin
          cnt_model = 16'h0000;
          continue;
        end
        chk($sformatf("d%0d frame bits", g), obs, exp_frame(b, PEN[g], PODD[g]));
        chk($sformatf("d%0d bit width/busy", g), 32'(stable), 32'd1);
        chk($sformatf("d%0d tx_done cycle", g), done_at, FL - 1);
        cnt_model = cnt_model + 16'd1;
      end
    end
  end

  task automatic push(input int k, input logic [7:0] b);
    push_dat    = b;
    push_req[k] = 1'b1;
    @(posedge clk);
    #2;
    push_req[k] = 1'b0;
  endtask

  task automatic wait_cnt(input int k, input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (cnt_v[k] !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cnt_v[k], target);
  endtask

  task automatic wait_low(input int k, input int budget, input string tag);
    int n = 0;
    while (txd_v[k] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, txd_v[k], 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n_rd, n_txd0, n_busy;
    rst_v    = '1;
    en_v     = '0;
    push_req = '0;
    push_dat = 8'h00;
    @(posedge clk);
    #2;
    en_v = '1;
    push(0, 8'hA5);
    push(1, 8'hA5);
    push(2, 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("d0 reset txd", txd_v[0], 1);
    chk("d0 reset busy", busy_v[0], 0);
    chk("d0 reset rd_en", rd_v[0], 0);
    chk("d0 reset tx_done", done_v[0], 0);
    chk("d0 reset tx_count", cnt_v[0], 0);

    // Single frames: plain, even parity, odd parity.
    @(posedge clk);
    #2;
    rst_v[2:0] = '0;
    wait_cnt(0, 16'd1, 400, "d0 count after 0xA5");
    wait_cnt(1, 16'd1, 400, "d1 count after 0xA5");
    wait_cnt(2, 16'd1, 400, "d2 count after 0x01");
    chk("d0 rd pulses one frame", rdc_v[0], 1);
    chk("d1 rd pulses one frame", rdc_v[1], 1);

    // Empty FIFO with enable high.
    n_rd = 0;
    n_txd0 = 0;
    n_busy = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_v[0] !== 1'b0) n_rd++;
      if (txd_v[0] !== 1'b1) n_txd0++;
      if (busy_v[0] !== 1'b0) n_busy++;
    end
    chk("d0 empty rd_en cycles", n_rd, 0);
    chk("d0 empty txd low cycles", n_txd0, 0);
    chk("d0 empty busy cycles", n_busy, 0);

    // Back-to-back frames, latency 2, two stop bits.
    push(3, 8'h00);
    push(3, 8'hFF);
    push(3, 8'h3C);
    rst_v[3] = 1'b0;
    wait_cnt(3, 16'd3, 1500, "d3 count after three frames");
    repeat (20) @(negedge clk);
    chk("d3 rd pulses", rdc_v[3], 3);
    chk("d3 frames seen", g_dut[3].gaps.size(), 3);
    if (g_dut[3].gaps.size() >= 3) begin
      chk("d3 gap before frame 2", g_dut[3].gaps[1], 3);
      chk("d3 gap before frame 3", g_dut[3].gaps[2], 3);
    end

    // Asynchronous reset in the middle of a data bit.
    push(0, 8'h55);
    push(0, 8'h3C);
    wait_low(0, 100, "d0 start of 0x55");
    repeat (25) @(posedge clk);
    #2;
    chk("d0 txd low before reset", txd_v[0], 0);
    rst_v[0] = 1'b1;
    #1;
    chk("d0 txd on async reset", txd_v[0], 1);
    chk("d0 busy on async reset", busy_v[0], 0);
    chk("d0 count on async reset", cnt_v[0], 0);
    repeat (2) @(posedge clk);
    #2;
    rst_v[0] = 1'b0;
    wait_cnt(0, 16'd1, 400, "d0 count after reset resume");
    chk("d0 rd pulses after reset", rdc_v[0], 3);

    // Enable dropped during START: frame finishes, nothing further read.
    push(0, 8'h11);
    push(0, 8'h22);
    wait_low(0, 100, "d0 start of 0x11");
    @(posedge clk);
    #2;
    en_v[0] = 1'b0;
    wait_cnt(0, 16'd2, 400, "d0 count after 0x11");
    repeat (50) @(negedge clk);
    chk("d0 rd pulses with enable low", rdc_v[0], 4);
    chk("d0 busy with enable low", busy_v[0], 0);
    @(posedge clk);
    #2;
    en_v[0] = 1'b1;
    wait_cnt(0, 16'd3, 400, "d0 count after re-enable");
    chk("d0 rd pulses after re-enable", rdc_v[0], 5);

    repeat (5) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("d%0d underflow reads", k), uf_v[k], 0);
      chk($sformatf("d%0d stray tx_done", k), stray_v[k], 0);
      chk($sformatf("d%0d bytes not sent", k), left_v[k], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
